// File: rtl/dma_arbiter.sv
// dma_arbiter: bus-ownership sequencer between the 6502 CPU and the MARIA
// DMA engine. Turns WSYNC writes into a CPU RDY stall until the next
// scanline start, halts the CPU on a read cycle before handing the address
// bus to DMA, and hands the bus back once DMA completes.
//
// Optional feature: define DMA_WATCHDOG_EN to compile in a grant watchdog
// that forces the bus back after WD_LIMIT clk_sys cycles and sets the
// sticky wd_error flag.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | CPU owns the bus and runs (rdy=1)
// WSYNC    | CPU stalled until the next line_start
// HALT_REQ | halt asserted, waiting for a phase-0 edge on a read cycle
// DMA      | DMA engine owns the bus, MARIA drives the address lines
// RELEASE  | bus handed back, halt held until the next phase-0 edge

module dma_arbiter #(
    parameter logic [15:0] WD_LIMIT = 16'd1200
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic pclk0,
    input  logic line_start,
    input  logic dma_en,
    input  logic wsync,
    input  logic dma_req,
    input  logic dma_done,
    input  logic cpu_rw,
    output logic rdy,
    output logic halt,
    output logic dma_grant,
    output logic drive_AB,
    output logic wd_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WSYNC,
        S_HALT_REQ,
        S_DMA,
        S_RELEASE
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   wsync_pend;
    logic   pend_nxt;
    logic   wd_trip;
    logic   dma_ask;

    assign dma_ask = dma_req && dma_en;

`ifdef DMA_WATCHDOG_EN
    logic [15:0] wd_cnt;

    // A dma_done on the limit cycle is a normal completion, not a trip.
    assign wd_trip = (state == S_DMA) && !dma_done && (wd_cnt == WD_LIMIT);
`else
    // WD_LIMIT has no effect without the watchdog; the term folds to 0.
    assign wd_trip  = 1'b0 && (WD_LIMIT != 16'd0);
    assign wd_error = 1'b0;
`endif

    // Next-state and pending-WSYNC decision from the current state and inputs.
    always_comb begin
        state_nxt = state;
        pend_nxt  = wsync_pend;
        case (state)
            S_IDLE: begin
                if (dma_ask) begin
                    state_nxt = S_HALT_REQ;
                    pend_nxt  = wsync && pclk0;
                end else if (wsync && pclk0) begin
                    state_nxt = S_WSYNC;
                end
            end
            S_WSYNC: begin
                if (line_start) begin
                    state_nxt = S_IDLE;
                end else if (dma_ask) begin
                    state_nxt = S_HALT_REQ;
                    pend_nxt  = 1'b1;
                end
            end
            S_HALT_REQ: begin
                if (line_start) begin
                    pend_nxt = 1'b0;
                end
                if (pclk0 && cpu_rw) begin
                    state_nxt = S_DMA;
                end
            end
            S_DMA: begin
                if (line_start) begin
                    pend_nxt = 1'b0;
                end
                if (dma_done || wd_trip) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (pclk0) begin
                    state_nxt = (wsync_pend && !line_start) ? S_WSYNC : S_IDLE;
                    pend_nxt  = 1'b0;
                end else if (line_start) begin
                    pend_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    // State register with outputs decoded from the next state so they are registered.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= S_IDLE;
            wsync_pend <= 1'b0;
            rdy        <= 1'b1;
            halt       <= 1'b0;
            dma_grant  <= 1'b0;
            drive_AB   <= 1'b0;
`ifdef DMA_WATCHDOG_EN
            wd_cnt     <= 16'd0;
            wd_error   <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            wsync_pend <= pend_nxt;
            rdy        <= (state_nxt == S_IDLE);
            halt       <= (state_nxt == S_HALT_REQ) || (state_nxt == S_DMA) ||
                          (state_nxt == S_RELEASE);
            dma_grant  <= (state_nxt == S_DMA);
            drive_AB   <= (state_nxt == S_DMA);
`ifdef DMA_WATCHDOG_EN
            if (state != S_DMA) begin
                wd_cnt <= 16'd0;
            end else begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (wd_trip) begin
                wd_error <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter: vector table, directed corner sequences and a randomized
// run against a bus-ownership reference model for dma_arbiter.

module tb_dma_arbiter;

    localparam logic [15:0] LIMIT = 16'd16;

    logic clk_sys = 1'b0;
    logic reset, pclk0, line_start, dma_en, wsync, dma_req, dma_done, cpu_rw;
    logic rdy, halt, dma_grant, drive_AB, wd_error;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    dma_arbiter #(.WD_LIMIT(LIMIT)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .pclk0     (pclk0),
        .line_start(line_start),
        .dma_en    (dma_en),
        .wsync     (wsync),
        .dma_req   (dma_req),
        .dma_done  (dma_done),
        .cpu_rw    (cpu_rw),
        .rdy       (rdy),
        .halt      (halt),
        .dma_grant (dma_grant),
        .drive_AB  (drive_AB),
        .wd_error  (wd_error)
    );

    // Reference model: who owns the bus (phase) and whether the CPU still
    // owes a WSYNC stall. phase 0 = CPU side, 1 = waiting for a read cycle,
    // 2 = DMA holds the bus, 3 = handing back.
    int   m_phase = 0;
    logic m_owe   = 1'b0;
    logic m_err   = 1'b0;
    int   m_cnt   = 0;

    always @(posedge clk_sys) begin
        automatic int   ph  = m_phase;
        automatic logic owe = m_owe;
        automatic logic err = m_err;
        automatic int   cnt = m_cnt;
        if (reset) begin
            ph = 0; owe = 1'b0; err = 1'b0; cnt = 0;
        end else if (ph == 0) begin
            if (owe) begin
                if (line_start) owe = 1'b0;
                else if (dma_req && dma_en) ph = 1;
            end else if (dma_req && dma_en) begin
                ph  = 1;
                owe = wsync && pclk0;
            end else if (wsync && pclk0) begin
                owe = 1'b1;
            end
        end else begin
            if (line_start) owe = 1'b0;
            if (ph == 1) begin
                if (pclk0 && cpu_rw) begin ph = 2; cnt = 0; end
            end else if (ph == 2) begin
                if (dma_done) ph = 3;
`ifdef DMA_WATCHDOG_EN
                else if (cnt == int'(LIMIT)) begin ph = 3; err = 1'b1; end
                else cnt = cnt + 1;
`endif
            end else begin
                if (pclk0) ph = 0;
            end
        end
        m_phase <= ph;
        m_owe   <= owe;
        m_err   <= err;
        m_cnt   <= cnt;
    end

    wire m_rdy   = (m_phase == 0) && !m_owe;
    wire m_halt  = (m_phase != 0);
    wire m_grant = (m_phase == 2);

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic pulses_off();
        pclk0 = 1'b0; line_start = 1'b0; wsync = 1'b0; dma_done = 1'b0;
    endtask

    // Drive the arbiter from IDLE into DMA (one read-cycle phase-0 edge).
    task automatic enter_dma();
        dma_en = 1'b1; dma_req = 1'b1; tick();
        pclk0 = 1'b1; cpu_rw = 1'b1; tick();
        pclk0 = 1'b0; dma_req = 1'b0;
    endtask

    typedef struct packed {
        logic rst, pclk, ls, en, ws, req, done, rw;
        logic e_rdy, e_halt, e_grant;
    } vec_t;

    vec_t vecs[21];

    initial begin
        automatic int   n;
        automatic logic seen;

        reset = 1'b1; cpu_rw = 1'b1; dma_en = 1'b0; dma_req = 1'b0;
        pulses_off();

        //           rst pclk ls en ws req done rw  rdy halt grant
        vecs[0]  = 11'b1_0_0_0_0_0_0_1___1_0_0;
        vecs[1]  = 11'b0_0_0_0_0_0_0_1___1_0_0;
        vecs[2]  = 11'b0_1_0_0_1_0_0_1___0_0_0; // WSYNC write
        vecs[3]  = 11'b0_0_0_0_0_0_0_1___0_0_0;
        vecs[4]  = 11'b0_0_1_0_0_0_0_1___1_0_0; // line start releases
        vecs[5]  = 11'b0_1_1_0_1_0_0_1___0_0_0; // coincident wsync+line_start
        vecs[6]  = 11'b0_0_1_0_0_0_0_1___1_0_0; // following line_start
        vecs[7]  = 11'b0_1_0_1_0_1_0_0___0_1_0; // request -> halt
        vecs[8]  = 11'b0_1_0_1_0_1_0_0___0_1_0; // write cycle: no grant
        vecs[9]  = 11'b0_1_0_1_0_1_0_1___0_1_1; // read cycle: grant
        vecs[10] = 11'b0_0_0_0_0_0_0_1___0_1_1; // dma_en drop does not abort
        vecs[11] = 11'b0_0_0_1_0_0_1_1___0_1_0; // done -> release
        vecs[12] = 11'b0_0_0_1_0_0_0_1___0_1_0;
        vecs[13] = 11'b0_1_0_1_0_0_0_1___1_0_0; // phase-0 edge returns bus
        vecs[14] = 11'b0_0_0_0_0_1_0_1___1_0_0; // request ignored when disabled
        vecs[15] = 11'b0_1_0_1_1_1_0_1___0_1_0; // req beats wsync, stall owed
        vecs[16] = 11'b0_1_0_1_0_0_0_1___0_1_1;
        vecs[17] = 11'b0_0_0_1_0_0_1_1___0_1_0;
        vecs[18] = 11'b0_1_0_1_0_0_0_1___0_0_0; // back to WSYNC stall
        vecs[19] = 11'b0_0_1_1_0_0_0_1___1_0_0;
        vecs[20] = 11'b0_0_0_1_0_0_1_1___1_0_0; // stray done ignored

        for (int i = 0; i < 21; i++) begin
            reset = vecs[i].rst; pclk0 = vecs[i].pclk; line_start = vecs[i].ls;
            dma_en = vecs[i].en; wsync = vecs[i].ws; dma_req = vecs[i].req;
            dma_done = vecs[i].done; cpu_rw = vecs[i].rw;
            tick();
            chk($sformatf("vec%0d_rdy", i), rdy, vecs[i].e_rdy);
            chk($sformatf("vec%0d_halt", i), halt, vecs[i].e_halt);
            chk($sformatf("vec%0d_grant", i), dma_grant, vecs[i].e_grant);
            chk($sformatf("vec%0d_drive", i), drive_AB, vecs[i].e_grant);
            chk($sformatf("vec%0d_wderr", i), wd_error, 1'b0);
        end
        pulses_off(); reset = 1'b0; dma_req = 1'b0; dma_en = 1'b0; tick();

        // Long WSYNC stall released by a line_start 300 clocks later.
        pclk0 = 1'b1; wsync = 1'b1; tick(); pulses_off();
        chk("wsync_stall_rdy", rdy, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 299; i++) begin tick(); seen = seen | rdy; end
        chk("wsync_hold_rdy", seen, 1'b0);
        line_start = 1'b1; tick(); pulses_off();
        chk("wsync_release_rdy", rdy, 1'b1);

        // Disabled DMA: a held request never halts the CPU.
        dma_en = 1'b0; dma_req = 1'b1; seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            pclk0 = (i % 4 == 0); tick(); seen = seen | halt | dma_grant;
        end
        pulses_off(); dma_req = 1'b0;
        chk("disabled_no_halt_grant", seen, 1'b0);

        // WSYNC then DMA, with line_start during DMA -> back to IDLE.
        pclk0 = 1'b1; wsync = 1'b1; tick(); pulses_off();
        enter_dma();
        chk("ws_dma_grant", dma_grant, 1'b1);
        line_start = 1'b1; tick(); pulses_off();
        dma_done = 1'b1; tick(); pulses_off();
        chk("ws_dma_release", dma_grant, 1'b0);
        pclk0 = 1'b1; tick(); pulses_off();
        chk("ws_ls_dma_rdy", rdy, 1'b1);
        chk("ws_ls_dma_halt", halt, 1'b0);

        // Grant without dma_done: watchdog trip or indefinite hold.
        enter_dma();
        chk("wd_entry_grant", dma_grant, 1'b1);
`ifdef DMA_WATCHDOG_EN
        n = 0;
        while (dma_grant && n < 100) begin tick(); n++; end
        chk("wd_trip_after_17", (n == 17), 1'b1);
        if (n != 17) $display("FAIL wd_trip_len: got %0d expected 17", n);
        chk("wd_error_set", wd_error, 1'b1);
        pclk0 = 1'b1; tick(); pulses_off();
        repeat (20) tick();
        chk("wd_error_sticky", wd_error, 1'b1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("wd_error_reset", wd_error, 1'b0);
`else
        n = 0;
        repeat (200) begin tick(); n = n + int'(dma_grant); end
        chk("nowd_grant_held", (n == 200), 1'b1);
        chk("nowd_wd_error", wd_error, 1'b0);
        dma_done = 1'b1; tick(); pulses_off();
        pclk0 = 1'b1; tick(); pulses_off();
        chk("nowd_back_idle", rdy, 1'b1);
`endif

        // Reset mid-DMA drops everything on the next clock.
        enter_dma();
        chk("rst_pre_grant", dma_grant, 1'b1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_mid_rdy", rdy, 1'b1);
        chk("rst_mid_halt", halt, 1'b0);
        chk("rst_mid_grant", dma_grant, 1'b0);
        chk("rst_mid_drive", drive_AB, 1'b0);

        // Randomized run against the reference model.
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 999) == 0);
            pclk0      = ($urandom_range(0, 3) == 0);
            wsync      = pclk0 && ($urandom_range(0, 7) == 0);
            line_start = ($urandom_range(0, 79) == 0);
            dma_en     = ($urandom_range(0, 9) != 0);
            cpu_rw     = $urandom_range(0, 1);
            dma_done   = ($urandom_range(0, 9) == 0);
            if (dma_grant) dma_req = 1'b0;
            else if (!dma_req && $urandom_range(0, 29) == 0) dma_req = 1'b1;
            tick();
            chk("rnd_rdy", rdy, m_rdy);
            chk("rnd_halt", halt, m_halt);
            chk("rnd_grant", dma_grant, m_grant);
            chk("rnd_drive", drive_AB, m_grant);
            chk("rnd_wderr", wd_error, m_err);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
